ram_arbiter: RTL and testbench

//   Shares the single-port data/frame RAM between two requesters: the CPU data

---
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares the single-port data/frame RAM between the CPU data port and the VGA
// pixel fetcher: VGA has priority, CPU starvation is bounded, and reads are tagged.
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int DATA_W     = 32,
    parameter int RAM_AW     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    // CPU data port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_wmask,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // VGA pixel fetcher
    input  logic              vga_req,
    input  logic [31:0]       vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    // RAM
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_VGA  = 2'd2
    } rd_tag_t;

    typedef struct packed {
        logic              en;
        logic [3:0]        we;
        logic [RAM_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_req_t;

    logic [CNT_W-1:0]  starve_cnt;
    rd_tag_t           rd_tag;
    logic              force_cpu;
    ram_req_t          ram_req;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_rdata_q;

    // Address bits outside the RAM word range are decoded upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cpu_addr[31:RAM_AW+2], cpu_addr[1:0],
                                vga_addr[31:RAM_AW+2], vga_addr[1:0]};

    // Grants are held low while reset is asserted so the RAM sees no strobe.
    always_comb begin
        force_cpu = cpu_req & (starve_cnt == CNT_MAX);
        vga_gnt   = reset_n & vga_req & ~force_cpu;
        cpu_gnt   = reset_n & cpu_req & ~vga_gnt;
    end

    always_comb begin
        ram_req       = '0;
        ram_req.en    = cpu_gnt | vga_gnt;
        ram_req.wdata = cpu_wdata;
        if (cpu_gnt) begin
            ram_req.addr = cpu_addr[RAM_AW+1:2];
            ram_req.we   = cpu_we ? cpu_wmask : 4'b0000;
        end else begin
            ram_req.addr = vga_addr[RAM_AW+1:2];
        end
    end

    assign ram_en    = ram_req.en;
    assign ram_we    = ram_req.we;
    assign ram_addr  = ram_req.addr;
    assign ram_wdata = ram_req.wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (cpu_gnt || !cpu_req) begin
            starve_cnt <= '0;
        end else if (vga_gnt && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Tag each read with its owner; RAM data arrives the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_tag <= TAG_NONE;
        end else if (vga_gnt) begin
            rd_tag <= TAG_VGA;
        end else if (cpu_gnt && !cpu_we) begin
            rd_tag <= TAG_CPU;
        end else begin
            rd_tag <= TAG_NONE;
        end
    end

    assign cpu_rvalid = (rd_tag == TAG_CPU);
    assign vga_rvalid = (rd_tag == TAG_VGA);

    // rdata passes RAM data through on its return cycle and otherwise holds.
    assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign vga_rdata = vga_rvalid ? ram_rdata : vga_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            cpu_rdata_q <= cpu_rdata;
            vga_rdata_q <= vga_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: stimulus pushes expected read returns into
// per-owner queues; a monitor pops and compares whenever an rvalid appears.
`timescale 1ns/1ps

module tb_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_wmask;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_gnt, vga_rvalid;
    logic [31:0] vga_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        vga_q[$];
    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 0;

    ram_arbiter #(.DATA_W(32), .RAM_AW(10), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wmask(cpu_wmask),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM with byte enables, data valid one cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle, after the RAM has returned data.
    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
                    chk("cpu_rvalid_cycle", cyc, cpu_q[0].due);
                    void'(cpu_q.pop_front());
                end
            end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                chk("cpu_missing_rvalid", 32'd0, 32'd1);
                void'(cpu_q.pop_front());
            end
            if (vga_rvalid) begin
                if (vga_q.size() == 0) chk("vga_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    chk("vga_rdata", vga_rdata, vga_q[0].data);
                    chk("vga_rvalid_cycle", cyc, vga_q[0].due);
                    void'(vga_q.pop_front());
                end
            end else if (vga_q.size() != 0 && vga_q[0].due <= cyc) begin
                chk("vga_missing_rvalid", 32'd0, 32'd1);
                void'(vga_q.pop_front());
            end
        end
    end

    // One cycle of stimulus plus the expected grant, RAM drive and read return.
    task automatic step(input string nm,
                        input logic creq, input logic cwe, input logic [3:0] cmask,
                        input logic [31:0] caddr, input logic [31:0] cwdata,
                        input logic vreq, input logic [31:0] vaddr,
                        input logic egc, input logic egv,
                        input logic [9:0] eaddr, input logic [3:0] ewe,
                        input logic [31:0] erd, input bit push = 1);
        exp_t e;
        @(negedge clk);
        cpu_req = creq; cpu_we = cwe; cpu_wmask = cmask;
        cpu_addr = caddr; cpu_wdata = cwdata;
        vga_req = vreq; vga_addr = vaddr;
        #2;
        chk({nm, ".cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, egc});
        chk({nm, ".vga_gnt"}, {31'd0, vga_gnt}, {31'd0, egv});
        chk({nm, ".ram_en"},  {31'd0, ram_en},  {31'd0, egc | egv});
        if (egc | egv) begin
            chk({nm, ".ram_addr"}, {22'd0, ram_addr}, {22'd0, eaddr});
            chk({nm, ".ram_we"},   {28'd0, ram_we},   {28'd0, ewe});
            if (ewe != 4'b0000) chk({nm, ".ram_wdata"}, ram_wdata, cwdata);
        end
        e.data = erd;
        e.due  = cyc + 1;
        if (push && egc && !cwe) cpu_q.push_back(e);
        if (push && egv) vga_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, ".cpu_gnt"},    {31'd0, cpu_gnt},    32'd0);
        chk({nm, ".vga_gnt"},    {31'd0, vga_gnt},    32'd0);
        chk({nm, ".cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
        chk({nm, ".vga_rvalid"}, {31'd0, vga_rvalid}, 32'd0);
        chk({nm, ".ram_en"},     {31'd0, ram_en},     32'd0);
        chk({nm, ".ram_we"},     {28'd0, ram_we},     32'd0);
        chk({nm, ".cpu_rdata"},  cpu_rdata,           32'd0);
        chk({nm, ".vga_rdata"},  vga_rdata,           32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[4] = 32'hDEAD_BEEF;
        ram_rdata = '0;
        reset_n = 0;
        cpu_req = 0; cpu_we = 0; cpu_wmask = 0; cpu_addr = 0; cpu_wdata = 0;
        vga_req = 0; vga_addr = 0;
        repeat (2) @(negedge clk);
        #2 check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1;
        mon_en = 1;

        step("idle",     0, 0, 4'h0, 32'h0,        32'h0,    0, 32'h0,   0, 0, 10'd0, 4'h0, 32'h0);
        step("cpu_rd",   1, 0, 4'h0, 32'h10,       32'h0,    0, 32'h0,   1, 0, 10'd4, 4'h0, 32'hDEAD_BEEF);
        step("cpu_wr",   1, 1, 4'h3, 32'h8,        32'h1234, 0, 32'h0,   1, 0, 10'd2, 4'h3, 32'h0);
        step("cpu_rdbk", 1, 0, 4'hF, 32'h8,        32'h0,    0, 32'h0,   1, 0, 10'd2, 4'h0, 32'hA000_1234);
        step("cpu_hi",   1, 0, 4'h0, 32'hFFFF_F013, 32'h0,   0, 32'h0,   1, 0, 10'd4, 4'h0, 32'hDEAD_BEEF);

        // Contention: VGA wins four times, CPU is forced, VGA waits one cycle.
        step("cont0", 1, 0, 4'h0, 32'h40, 32'h0, 1, 32'h100, 0, 1, 10'd64, 4'h0, 32'hA000_0040);
        step("cont1", 1, 0, 4'h0, 32'h40, 32'h0, 1, 32'h104, 0, 1, 10'd65, 4'h0, 32'hA000_0041);
        step("cont2", 1, 0, 4'h0, 32'h40, 32'h0, 1, 32'h108, 0, 1, 10'd66, 4'h0, 32'hA000_0042);
        step("cont3", 1, 0, 4'h0, 32'h40, 32'h0, 1, 32'h10C, 0, 1, 10'd67, 4'h0, 32'hA000_0043);
        step("cont4", 1, 0, 4'h0, 32'h40, 32'h0, 1, 32'h110, 1, 0, 10'd16, 4'h0, 32'hA000_0010);
        step("cont5", 0, 0, 4'h0, 32'h0,  32'h0, 1, 32'h110, 0, 1, 10'd68, 4'h0, 32'hA000_0044);

        // Alternating owners on consecutive cycles.
        step("alt0", 0, 0, 4'h0, 32'h0,  32'h0, 1, 32'h20, 0, 1, 10'd8,  4'h0, 32'hA000_0008);
        step("alt1", 1, 0, 4'h0, 32'h24, 32'h0, 0, 32'h0,  1, 0, 10'd9,  4'h0, 32'hA000_0009);
        step("alt2", 0, 0, 4'h0, 32'h0,  32'h0, 1, 32'h28, 0, 1, 10'd10, 4'h0, 32'hA000_000A);
        step("alt3", 1, 0, 4'h0, 32'h2C, 32'h0, 0, 32'h0,  1, 0, 10'd11, 4'h0, 32'hA000_000B);

        // CPU withdraws while VGA streams: the starvation count restarts.
        step("wd0", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h200, 0, 1, 10'd128, 4'h0, 32'hA000_0080);
        step("wd1", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h204, 0, 1, 10'd129, 4'h0, 32'hA000_0081);
        step("wd2", 0, 0, 4'h0, 32'h0,  32'h0, 1, 32'h208, 0, 1, 10'd130, 4'h0, 32'hA000_0082);
        step("wd3", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h20C, 0, 1, 10'd131, 4'h0, 32'hA000_0083);
        step("wd4", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h210, 0, 1, 10'd132, 4'h0, 32'hA000_0084);
        step("wd5", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h214, 0, 1, 10'd133, 4'h0, 32'hA000_0085);
        step("wd6", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h218, 0, 1, 10'd134, 4'h0, 32'hA000_0086);
        step("wd7", 1, 0, 4'h0, 32'h80, 32'h0, 1, 32'h21C, 1, 0, 10'd32,  4'h0, 32'hA000_0020);
        step("wd8", 0, 0, 4'h0, 32'h0,  32'h0, 1, 32'h21C, 0, 1, 10'd135, 4'h0, 32'hA000_0087);

        // Reset in the cycle a CPU read would return: the read is dropped.
        step("rst_rd", 1, 0, 4'h0, 32'h10, 32'h0, 0, 32'h0, 1, 0, 10'd4, 4'h0, 32'h0, 0);
        @(posedge clk);
        #1 reset_n = 0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        cpu_req = 0;
        @(negedge clk);
        reset_n = 1;
        step("post_rst", 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 10'd0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        #5;
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("vga_q_drained", vga_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
